hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Drives en/clr of the IF/ID, ID/EX,
//  EX/MEM and MEM/WB pipeline registers plus PC enable. Handles load-use stalls, EX-resolved

---
 rtl/hazard_ctrl_pkg.sv | 29 ++
 rtl/hazard_ctrl_perf.sv | 45 ++++
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        MD_WAIT  = 2'b10
    } hz_state_e;

    typedef struct packed {
        logic en;
        logic clr;
    } stage_ctl_t;

    localparam logic [31:0] REG_ZERO = '0;

    localparam stage_ctl_t CTL_RUN   = '{en: 1'b1, clr: 1'b0};
    localparam stage_ctl_t CTL_HOLD  = '{en: 1'b0, clr: 1'b0};
    localparam stage_ctl_t CTL_FLUSH = '{en: 1'b1, clr: 1'b1};

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_perf.sv
// ============================================================================
// Module      : hazard_ctrl_perf
// Description : Bank of three saturating event counters (stall, flush, load-use).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl_perf #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_inc,
    input  logic                 flush_inc,
    input  logic                 loaduse_inc,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt,
    output logic [CNT_WIDTH-1:0] loaduse_cnt
);

    logic [2:0]           w_inc;
    logic [CNT_WIDTH-1:0] r_cnt [3];

    assign w_inc = {loaduse_inc, flush_inc, stall_inc};

    generate
        for (genvar i = 0; i < 3; i++) begin : g_cnt
            // Counters stick at all-ones rather than wrapping.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt[i] <= '0;
                end else if (w_inc[i] && (r_cnt[i] != {CNT_WIDTH{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    endgenerate

    assign stall_cnt   = r_cnt[0];
    assign flush_cnt   = r_cnt[1];
    assign loaduse_cnt = r_cnt[2];

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall/flush sequencer for the 5-stage pipeline. Optional
//               performance counters are built when PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_use_rs1,
    input  logic                      id_use_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_mem_read,
    input  logic                      ex_br_taken,
    input  logic                      ex_md_start,
    input  logic                      md_done,
    input  logic                      mem_req,
    input  logic                      mem_ready,
    output logic                      pc_en,
    output logic                      if_id_en,
    output logic                      if_id_clr,
    output logic                      id_ex_en,
    output logic                      id_ex_clr,
    output logic                      ex_mem_en,
    output logic                      ex_mem_clr,
    output logic                      mem_wb_en,
    output logic                      mem_wb_clr,
    output logic [1:0]                state_o
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt,
    output logic [CNT_WIDTH-1:0]      loaduse_cnt
`endif
);

    hz_state_e  r_state;
    logic       r_md_done_q;

    logic       w_memfrz;
    logic       w_mdstall;
    logic       w_loaduse;
    logic       w_pc_en;
    stage_ctl_t w_if_id;
    stage_ctl_t w_id_ex;
    stage_ctl_t w_ex_mem;
    stage_ctl_t w_mem_wb;

    assign w_memfrz  = mem_req & ~mem_ready;
    assign w_mdstall = ((r_state == MD_WAIT) & ~(md_done | r_md_done_q)) |
                       ((r_state == RUN) & ex_md_start & ~md_done);
    assign w_loaduse = ex_mem_read & (ex_rd != REG_ZERO[REG_ADDR_WIDTH-1:0]) &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) |
                        (id_use_rs2 & (id_rs2 == ex_rd)));

    // Priority: reset, memory freeze, MUL/DIV stall, branch flush, load-use.
    always_comb begin
        w_pc_en  = 1'b1;
        w_if_id  = CTL_RUN;
        w_id_ex  = CTL_RUN;
        w_ex_mem = CTL_RUN;
        w_mem_wb = CTL_RUN;
        if (rst || w_memfrz) begin
            w_pc_en  = 1'b0;
            w_if_id  = CTL_HOLD;
            w_id_ex  = CTL_HOLD;
            w_ex_mem = CTL_HOLD;
            w_mem_wb = CTL_HOLD;
        end else if (w_mdstall) begin
            w_pc_en  = 1'b0;
            w_if_id  = CTL_HOLD;
            w_id_ex  = CTL_HOLD;
            w_ex_mem = CTL_FLUSH;
        end else if (ex_br_taken) begin
            w_if_id  = CTL_FLUSH;
            w_id_ex  = CTL_FLUSH;
        end else if (w_loaduse) begin
            w_pc_en  = 1'b0;
            w_if_id  = CTL_HOLD;
            w_id_ex  = CTL_FLUSH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_md_done_q <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_memfrz) begin
                        r_state <= MEM_WAIT;
                    end else if (ex_md_start && !md_done) begin
                        r_state <= MD_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        r_state <= RUN;
                    end
                end
                MD_WAIT: begin
                    // A completion seen while frozen is remembered until the pipe moves.
                    if (!w_memfrz && (md_done || r_md_done_q)) begin
                        r_state     <= RUN;
                        r_md_done_q <= 1'b0;
                    end else if (w_memfrz && md_done) begin
                        r_md_done_q <= 1'b1;
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign pc_en      = w_pc_en;
    assign if_id_en   = w_if_id.en;
    assign if_id_clr  = w_if_id.clr;
    assign id_ex_en   = w_id_ex.en;
    assign id_ex_clr  = w_id_ex.clr;
    assign ex_mem_en  = w_ex_mem.en;
    assign ex_mem_clr = w_ex_mem.clr;
    assign mem_wb_en  = w_mem_wb.en;
    assign mem_wb_clr = w_mem_wb.clr;
    assign state_o    = rst ? RUN : r_state;

`ifdef PERF_CNT_EN
    logic w_stall_ev;
    logic w_flush_ev;
    logic w_loaduse_ev;

    assign w_stall_ev   = ~rst & (w_memfrz | w_mdstall);
    assign w_flush_ev   = ~rst & ~w_memfrz & ~w_mdstall & ex_br_taken;
    assign w_loaduse_ev = ~rst & ~w_memfrz & ~w_mdstall & ~ex_br_taken & w_loaduse;

    hazard_ctrl_perf #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_perf (
        .clk         (clk),
        .rst         (rst),
        .stall_inc   (w_stall_ev),
        .flush_inc   (w_flush_ev),
        .loaduse_inc (w_loaduse_ev),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .loaduse_cnt (loaduse_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl (PERF_CNT_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int RAW = 5;
`ifdef PERF_CNT_EN
    localparam int CW  = 2;
`else
    localparam int CW  = 32;
`endif

    // {pc, if_id en/clr, id_ex en/clr, ex_mem en/clr, mem_wb en/clr, state[1:0]}
    localparam logic [10:0] V_RST     = 11'b000_0000_0000;
    localparam logic [10:0] V_RUN     = 11'b110_1010_1000;
    localparam logic [10:0] V_RUN_MW  = 11'b110_1010_1001;
    localparam logic [10:0] V_RUN_MD  = 11'b110_1010_1010;
    localparam logic [10:0] V_LU      = 11'b000_1110_1000;
    localparam logic [10:0] V_BR      = 11'b111_1110_1000;
    localparam logic [10:0] V_FRZ     = 11'b000_0000_0000;
    localparam logic [10:0] V_FRZ_MW  = 11'b000_0000_0001;
    localparam logic [10:0] V_FRZ_MD  = 11'b000_0000_0010;
    localparam logic [10:0] V_MDS     = 11'b000_0011_1000;
    localparam logic [10:0] V_MDS_MD  = 11'b000_0011_1010;

    logic           clk = 1'b0;
    logic           rst;
    logic [RAW-1:0] id_rs1, id_rs2, ex_rd;
    logic           id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken;
    logic           ex_md_start, md_done, mem_req, mem_ready;
    logic           pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr;
    logic           ex_mem_en, ex_mem_clr, mem_wb_en, mem_wb_clr;
    logic [1:0]     state_o;
`ifdef PERF_CNT_EN
    logic [CW-1:0]  stall_cnt, flush_cnt, loaduse_cnt;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_ADDR_WIDTH (RAW),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_br_taken (ex_br_taken),
        .ex_md_start (ex_md_start),
        .md_done     (md_done),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .if_id_clr   (if_id_clr),
        .id_ex_en    (id_ex_en),
        .id_ex_clr   (id_ex_clr),
        .ex_mem_en   (ex_mem_en),
        .ex_mem_clr  (ex_mem_clr),
        .mem_wb_en   (mem_wb_en),
        .mem_wb_clr  (mem_wb_clr),
        .state_o     (state_o)
`ifdef PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .loaduse_cnt (loaduse_cnt)
`endif
    );

    logic [10:0] w_ov;
    assign w_ov = {pc_en, if_id_en, if_id_clr, id_ex_en, id_ex_clr,
                   ex_mem_en, ex_mem_clr, mem_wb_en, mem_wb_clr, state_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0; ex_br_taken = 1'b0;
        ex_md_start = 1'b0; md_done = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Inputs already applied; sample mid-cycle, then advance past the next edge.
    task automatic cyc(input string tag, input logic [10:0] exp);
        @(negedge clk);
        check(tag, 32'(w_ov), 32'(exp));
        @(posedge clk);
        #1;
    endtask

`ifdef PERF_CNT_EN
    task automatic chk_perf(input string tag, input int s, input int f, input int l);
        @(negedge clk);
        check({tag, "_stall"},   32'(stall_cnt),   32'(s));
        check({tag, "_flush"},   32'(flush_cnt),   32'(f));
        check({tag, "_loaduse"}, 32'(loaduse_cnt), 32'(l));
    endtask
`endif

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        cyc("reset", V_RST);
        rst = 1'b0;
`ifdef PERF_CNT_EN
        chk_perf("p_reset", 0, 0, 0);
`endif
        cyc("idle", V_RUN);

        // Load-use detection on rs1 / rs2, x0 and unused-operand exclusions
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        cyc("lu_rs1", V_LU);
        ex_mem_read = 1'b0;
        cyc("lu_bubble", V_RUN);
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        cyc("lu_x0", V_RUN);
        ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        cyc("lu_rs2", V_LU);
        id_use_rs2 = 1'b0;
        cyc("lu_nouse", V_RUN);

        // Taken branch outranks load-use
        id_use_rs2 = 1'b1; ex_br_taken = 1'b1;
        cyc("br_over_lu", V_BR);
        idle();
`ifdef PERF_CNT_EN
        chk_perf("p_mid", 0, 1, 2);
`endif

        // Data-memory wait: three frozen cycles, branch held off while frozen
        mem_req = 1'b1; mem_ready = 1'b0;
        cyc("mem_frz1", V_FRZ);
        ex_br_taken = 1'b1;
        cyc("mem_frz2", V_FRZ_MW);
        ex_br_taken = 1'b0;
        cyc("mem_frz3", V_FRZ_MW);
        mem_ready = 1'b1;
        cyc("mem_release", V_RUN_MW);
        idle();
        cyc("mem_after", V_RUN);

        // MUL/DIV finishing the cycle it starts: no stall
        ex_md_start = 1'b1; md_done = 1'b1;
        cyc("md_same", V_RUN);
        idle();
        cyc("md_same_after", V_RUN);

        // MUL/DIV with four stall cycles then release
        ex_md_start = 1'b1;
        cyc("md_stall1", V_MDS);
        cyc("md_stall2", V_MDS_MD);
        cyc("md_stall3", V_MDS_MD);
        cyc("md_stall4", V_MDS_MD);
        md_done = 1'b1;
        cyc("md_release", V_RUN_MD);
        idle();
        cyc("md_after", V_RUN);

        // md_done arrives under a memory freeze and is remembered
        ex_md_start = 1'b1;
        cyc("mdq_start", V_MDS);
        mem_req = 1'b1; mem_ready = 1'b0; md_done = 1'b1;
        cyc("mdq_frz1", V_FRZ_MD);
        md_done = 1'b0;
        cyc("mdq_frz2", V_FRZ_MD);
        mem_ready = 1'b1;
        cyc("mdq_release", V_RUN_MD);
        idle();
        cyc("mdq_after", V_RUN);
`ifdef PERF_CNT_EN
        chk_perf("p_sat", 3, 1, 2);
`endif

        // Reset in the middle of a MUL/DIV wait
        ex_md_start = 1'b1;
        cyc("rst_md1", V_MDS);
        cyc("rst_md2", V_MDS_MD);
        idle();
        rst = 1'b1;
        cyc("rst_mid", V_RST);
        rst = 1'b0;
`ifdef PERF_CNT_EN
        chk_perf("p_clear", 0, 0, 0);
`endif
        cyc("rst_after", V_RUN);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
